// File: rtl/kronos_mtimer_if.sv
// Single-beat Wishbone-style bus bundle for the machine timer register port.
interface kronos_mtimer_if;
    logic        wb_cyc;
    logic        wb_stb;
    logic        wb_we;
    logic [4:0]  wb_adr;
    logic [31:0] wb_dat_i;
    logic [31:0] wb_dat_o;
    logic        wb_ack;

    modport master (
        output wb_cyc, wb_stb, wb_we, wb_adr, wb_dat_i,
        input  wb_dat_o, wb_ack
    );

    modport slave (
        input  wb_cyc, wb_stb, wb_we, wb_adr, wb_dat_i,
        output wb_dat_o, wb_ack
    );
endinterface

// File: rtl/kronos_mtimer.sv
// Machine timer (mtime/mtimecmp) and software interrupt (msip) register block.
// mtime advances once every PRESCALE core cycles; the interrupt outputs are
// registered levels that feed the machine-level CSR block.
module kronos_mtimer #(
    parameter int unsigned PRESCALE = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    kronos_mtimer_if.slave        bus,
    output logic                  timer_interrupt,
    output logic                  software_interrupt
);

    localparam logic [15:0] PS_LAST = 16'(PRESCALE - 1);

    logic [15:0] pcnt_q, pcnt_d;
    logic [63:0] mtime_q, mtime_d;
    logic [63:0] mtimecmp_q, mtimecmp_d;
    logic        msip_q, msip_d;
    logic        ack_q, ack_d;
    logic [31:0] dat_q, dat_d;
    logic        tint_q, tint_d;
    logic        sint_q, sint_d;

    logic        accept;
    logic        wr;
    logic        tick;
    logic [31:0] rdata;

    // Byte lanes are not supported; the low address bits carry no information.
    logic unused_adr;
    assign unused_adr = ^bus.wb_adr[1:0];

    // Accept a request only while no ack is outstanding, so every access costs two cycles.
    always_comb begin
        accept = bus.wb_cyc & bus.wb_stb & ~ack_q;
        wr     = accept & bus.wb_we;
        tick   = (pcnt_q == PS_LAST);
    end

    // Read mux over the word-addressed register map; unmapped words read as zero.
    always_comb begin
        rdata = '0;
        case (bus.wb_adr[4:2])
            3'd0:    rdata = mtime_q[31:0];
            3'd1:    rdata = mtime_q[63:32];
            3'd2:    rdata = mtimecmp_q[31:0];
            3'd3:    rdata = mtimecmp_q[63:32];
            3'd4:    rdata = {31'd0, msip_q};
            default: rdata = '0;
        endcase
    end

    // Next state: prescaler, mtime increment, register writes and registered outputs.
    always_comb begin
        pcnt_d     = tick ? '0 : pcnt_q + 16'd1;
        mtime_d    = tick ? mtime_q + 64'd1 : mtime_q;
        mtimecmp_d = mtimecmp_q;
        msip_d     = msip_q;

        // A write to either half of mtime overrides that cycle's increment; the
        // untouched half keeps its old value with no carry applied.
        if (wr) begin
            case (bus.wb_adr[4:2])
                3'd0:    mtime_d = {mtime_q[63:32], bus.wb_dat_i};
                3'd1:    mtime_d = {bus.wb_dat_i, mtime_q[31:0]};
                3'd2:    mtimecmp_d = {mtimecmp_q[63:32], bus.wb_dat_i};
                3'd3:    mtimecmp_d = {bus.wb_dat_i, mtimecmp_q[31:0]};
                3'd4:    msip_d = bus.wb_dat_i[0];
                default: ;
            endcase
        end

        ack_d  = accept;
        dat_d  = (accept & ~bus.wb_we) ? rdata : '0;
        tint_d = (mtime_q >= mtimecmp_q);
        sint_d = msip_q;
    end

    // State registers with synchronous reset; a pending ack is dropped on reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            pcnt_q     <= '0;
            mtime_q    <= '0;
            mtimecmp_q <= '1;
            msip_q     <= 1'b0;
            ack_q      <= 1'b0;
            dat_q      <= '0;
            tint_q     <= 1'b0;
            sint_q     <= 1'b0;
        end else begin
            pcnt_q     <= pcnt_d;
            mtime_q    <= mtime_d;
            mtimecmp_q <= mtimecmp_d;
            msip_q     <= msip_d;
            ack_q      <= ack_d;
            dat_q      <= dat_d;
            tint_q     <= tint_d;
            sint_q     <= sint_d;
        end
    end

    assign bus.wb_ack         = ack_q;
    assign bus.wb_dat_o       = dat_q;
    assign timer_interrupt    = tint_q;
    assign software_interrupt = sint_q;

endmodule
